// File: rtl/seq_delay_line_sdffe_if.sv
// Bus bundle for the programmable delay line: control and data in, selected tap out.
interface seq_delay_line_sdffe_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
);
  localparam int TW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [TW-1:0]    tap;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [TW-1:0]    count;

  modport master (
    output en, flush, d, d_valid, tap,
    input  q, q_valid, count
  );

  modport slave (
    input  en, flush, d, d_valid, tap,
    output q, q_valid, count
  );
endinterface

// File: rtl/seq_delay_line_sdffe.sv
// Programmable 1..DEPTH cycle delay line with clock enable, per-stage valid,
// synchronous flush, registered occupancy count and a run-time output tap.
module seq_delay_line_sdffe #(
  parameter int               WIDTH       = 2,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_delay_line_sdffe_if.slave bus
);
  localparam int TW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [TW-1:0]    count_p;
  logic [IW-1:0]    sel;

  // Occupancy after a shift: one word may enter and one may leave per edge,
  // so the count is maintained incrementally instead of re-counting the valids.
  function automatic logic [TW-1:0] next_count(input logic [TW-1:0] cur,
                                               input logic          in_vld,
                                               input logic          out_vld);
    return cur + TW'(in_vld) - TW'(out_vld);
  endfunction

  // Valid vector after one shift; the bit in the last stage falls off the end.
  function automatic logic [DEPTH-1:0] shift_valid(input logic [DEPTH-1:0] v,
                                                   input logic             b);
    logic [DEPTH-1:0] r;
    r    = '0;
    r[0] = b;
    for (int i = 1; i < DEPTH; i++) r[i] = v[i-1];
    return r;
  endfunction

  // Tap to stage index; out-of-range taps (0 or beyond DEPTH) fall back to the
  // last stage so the mux never selects a non-existent register.
  function automatic logic [IW-1:0] tap_index(input logic [TW-1:0] t);
    if (DEPTH == 1) return '0;
    if ((t == '0) || (int'(t) > DEPTH)) return IW'(DEPTH - 1);
    return IW'(t - 1'b1);
  endfunction

  // Data stages: shift on enable, hold on flush so stale words stay visible
  // but are marked invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) data_p[i] <= RESET_VALUE;
    end else if (!bus.flush && bus.en) begin
      data_p[0] <= bus.d;
      for (int i = 1; i < DEPTH; i++) data_p[i] <= data_p[i-1];
    end
  end

  // Valid bits and occupancy count: reset and flush both empty the line.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      vld_p   <= '0;
      count_p <= '0;
    end else if (bus.en) begin
      vld_p   <= shift_valid(vld_p, bus.d_valid);
      count_p <= next_count(count_p, bus.d_valid, vld_p[DEPTH-1]);
    end
  end

  // Output tap: purely combinational from the registers, only tap reaches q.
  assign sel         = tap_index(bus.tap);
  assign bus.q       = data_p[sel];
  assign bus.q_valid = vld_p[sel];
  assign bus.count   = count_p;

endmodule

// File: doc/seq_delay_line_sdffe.md
# seq_delay_line_sdffe

Parametrised synchronous-reset delay line: a WIDTH-bit, DEPTH-stage shift register with clock enable, a per-stage valid bit, a synchronous flush and a run-time selectable output tap. Successor to the fixed single-stage sdffe FIFO fixtures. Used as a generic pipeline-alignment element wherever a data path needs a programmable 1..DEPTH cycle delay with stall support.

## Interface
- WIDTH, 2, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- RESET_VALUE, 0, WIDTH-bit value loaded into every data stage on reset
- TW (localparam), $clog2(DEPTH+1), width of tap and count
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high reset
- en  input  1  advance enable; the line shifts only on cycles with en=1
- flush  input  1  synchronous clear of all valid bits
- d  input  WIDTH  input data
- d_valid  input  1  qualifier captured alongside d
- tap  input  TW  selected output stage, legal range 1..DEPTH
- q  output  WIDTH  data of the selected stage
- q_valid  output  1  valid bit of the selected stage
- count  output  TW  number of stages currently holding valid data

## Operation
- State: data registers stage[0..DEPTH-1], valid registers v[0..DEPTH-1], count register.
- Priority at each rising clk edge: reset > flush > en > hold.
- reset=1: every stage[i] <= RESET_VALUE, every v[i] <= 0, count <= 0.
- flush=1 (reset=0): every v[i] <= 0, count <= 0; data registers hold. No shift occurs even if en=1; the d/d_valid presented that cycle are dropped.
- en=1 (reset=0, flush=0): stage[0] <= d, v[0] <= d_valid; stage[i] <= stage[i-1] and v[i] <= v[i-1] for i=1..DEPTH-1; contents of stage[DEPTH-1] are discarded. d is captured even when d_valid=0.
- en=0: all registers hold.
- count always equals the popcount of v[] after the same edge. It is registered, not a combinational popcount of the current state, and is updated as count + d_valid - v[DEPTH-1] on a shift.
- Output selection: q = stage[tap-1], q_valid = v[tap-1]. This is a combinational mux from the registers, with no extra register stage.
- Illegal tap (0 or >DEPTH) selects stage DEPTH-1. No error flag is raised.
- DEPTH=1: tap is ignored and the block reduces to a single sdffe-style register with enable and valid.

## Timing
- Reset values: q = RESET_VALUE, q_valid = 0, count = 0 from the first edge with reset=1. Before any reset, values are undefined.
- Latency: a word accepted on edge N (en=1) appears on q when tap=t after t enabled edges, counting edge N as the first.
  - Example: t=1 gives q valid immediately after edge N.
  - With en held high, latency is t cycles.
  - Stall cycles (en=0) add one cycle each and do not lose data.
- Changing tap takes effect combinationally in the same cycle. The data already in the line is not re-timed.
- Reset asserted mid-stream clears everything at that edge. The first edge after deassertion behaves as a normal shift if en=1.
- Flush and reset are level-sensitive per edge. Holding either one for multiple cycles is equivalent to asserting it for one cycle.
- No combinational path from d, d_valid, en, flush or reset to any output. Only tap reaches q and q_valid combinationally.

## Test plan
- **Reset / stream:** WIDTH=2, DEPTH=4. Apply reset 2 cycles, then en=1 with d=1,2,3,0 and d_valid=1, tap=4.
  - q_valid=0 with q=0 until the 4th edge; then q=1, 2, 3, 0 on successive cycles.
  - count ramps 1, 2, 3, 4 and stays at 4.
- **Tap sweep:** fill the line with 3,2,1,0 (stage0=0). Set tap=1..4 with en=0.
  - q reads 0, 1, 2, 3 in the same cycle.
  - tap=0 and tap=7 both read 3.
- **Stall:** stream 1,2,3 with tap=2, holding en=0 for 3 cycles after the 2nd word.
  - q and q_valid hold during the stall.
  - Output order is 1, 2, 3 with no loss or duplication; count stays constant during the stall.
- **Bubbles:** shift a d_valid pattern 1,0,1,1 with tap=4.
  - q_valid sequence is 1,0,1,1 after a 4-cycle latency.
  - count peaks at 3 and decrements as valid words leave stage 3.
- **Flush vs en:** full line, assert flush and en together with d=2, d_valid=1.
  - Next cycle: all q_valid=0 for every tap, count=0, and stage data unchanged (no shift).
  - The following en cycle captures the new word into stage 0.
- **Reset priority:** assert reset, flush and en together mid-stream.
  - All stages become RESET_VALUE, valids become 0, count becomes 0.
  - Repeat with RESET_VALUE=3 and confirm q=3.
